// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Recovers the digits shown on a multiplexed 4-digit 7-segment display by
//   watching its segment and digit-select lines. Each digit is captured once
//   its segment/select pair has been stable for STABLE_CYCLES synchronized
//   cycles. When all four slots have been captured, the frame is published.
//
// Ports
//   clk         : single clock
//   rst_n       : asynchronous active-low reset
//   seg_in      : segment lines, bit6=g .. bit0=a, active-high
//   dig_sel     : one-hot digit enable, bit i selects digit i
//   digits_out  : last published frame, digit i in bits [4i+3:4i]
//   frame_valid : one-cycle pulse when digits_out updates
//   frame_err   : the published frame held an undecodable pattern
//   state_dbg   : current capture state (IDLE/SETTLE/HELD)
//
// Handshake: frame_valid is a push-only strobe with no ready; digits_out and
// frame_err are valid in the cycle frame_valid is high and hold until the
// next strobe.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] digits_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  // Returns {invalid, bcd}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = 5'h00;
      7'b0000110: decode = 5'h01;
      7'b1011011: decode = 5'h02;
      7'b1001111: decode = 5'h03;
      7'b1100110: decode = 5'h04;
      7'b1101101: decode = 5'h05;
      7'b1111101: decode = 5'h06;
      7'b0000111: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1101111: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [3:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [10:0] pair_prev_q, pair_prev_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  inv_q, inv_d;
  logic [15:0] slot_q, slot_d;
  logic [15:0] digits_q, digits_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;

  logic        one_hot;
  logic        changed;
  logic        capture;
  logic [1:0]  idx;
  logic [4:0]  dec;

  assign one_hot = (sel_s2_q != 4'd0) && ((sel_s2_q & (sel_s2_q - 4'd1)) == 4'd0);
  assign changed = ({seg_s2_q, sel_s2_q} != pair_prev_q);
  assign dec     = decode(seg_s2_q);

  always_comb begin
    case (sel_s2_q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    seg_s1_d    = seg_in;
    seg_s2_d    = seg_s1_q;
    sel_s1_d    = dig_sel;
    sel_s2_d    = sel_s1_q;
    pair_prev_d = {seg_s2_q, sel_s2_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    inv_d       = inv_q;
    slot_d      = slot_q;
    digits_d    = digits_q;
    fv_d        = 1'b0;
    err_d       = err_q;
    capture     = 1'b0;

    // Stability tracking on the synchronized pair.
    if (!one_hot) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (changed || state_q == IDLE) begin
      cnt_d   = 8'd1;
      state_d = SETTLE;
      if (STABLE_W == 8'd1) capture = 1'b1;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == STABLE_W) capture = 1'b1;
    end

    if (capture) state_d = HELD;

    // Publish first so a capture in the same cycle lands in the new frame.
    if (mask_q == 4'hF) begin
      digits_d = slot_q;
      fv_d     = 1'b1;
      err_d    = |inv_q;
      mask_d   = 4'h0;
      inv_d    = 4'h0;
    end

    if (capture) begin
      slot_d[{idx, 2'b00} +: 4] = dec[3:0];
      inv_d[idx]                = dec[4];
      mask_d[idx]               = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q    <= '0;
      seg_s2_q    <= '0;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      pair_prev_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      inv_q       <= '0;
      slot_q      <= '0;
      digits_q    <= '0;
      fv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      seg_s1_q    <= seg_s1_d;
      seg_s2_q    <= seg_s2_d;
      sel_s1_q    <= sel_s1_d;
      sel_s2_q    <= sel_s2_d;
      pair_prev_q <= pair_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      inv_q       <= inv_d;
      slot_q      <= slot_d;
      digits_q    <= digits_d;
      fv_q        <= fv_d;
      err_q       <= err_d;
    end
  end

  assign digits_out  = digits_q;
  assign frame_valid = fv_q;
  assign frame_err   = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  localparam int STABLE = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] digits_out;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .digits_out  (digits_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [16:0] exp_q[$];   // {err, digits}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] ref_pat [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  logic [10:0] run_pair;
  int          run_len;
  logic [3:0]  m_mask;
  logic [3:0]  m_slot [0:3];
  logic        m_inv  [0:3];

  function automatic logic [4:0] decode_ref(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (p == ref_pat[i]) return {1'b0, 4'(i)};
    return 5'h1F;
  endfunction

  task automatic model_reset();
    run_pair = '0;
    run_len  = 0;
    m_mask   = '0;
    for (int i = 0; i < 4; i++) begin
      m_slot[i] = '0;
      m_inv[i]  = 1'b0;
    end
  endtask

  // One pin cycle: a digit is captured when its one-hot pair has been shown
  // for exactly STABLE consecutive cycles; a full set of four makes a frame.
  task automatic model_step(input logic [6:0] s, input logic [3:0] d);
    logic [4:0] v;
    int         k;
    if ({s, d} != run_pair) begin
      run_pair = {s, d};
      run_len  = 1;
    end else if (run_len < 100000) begin
      run_len++;
    end
    if ($countones(d) == 1 && run_len == STABLE) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (d[i]) k = i;
      v = decode_ref(s);
      m_slot[k] = v[3:0];
      m_inv[k]  = v[4];
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_q.push_back({m_inv[0] | m_inv[1] | m_inv[2] | m_inv[3],
                         m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
        m_mask = '0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      seg_in  = s;
      dig_sel = d;
      model_step(s, d);
      @(negedge clk);
    end
  endtask

  task automatic show(input int dig, input int val, input int n);
    drive(ref_pat[val], 4'(1 << dig), n);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    seg_in  = '0;
    dig_sel = '0;
    #1;
    check("reset_digits", 32'(digits_out), 32'h0);
    check("reset_valid", 32'(frame_valid), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] last_d;
  logic        last_e;

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      last_d = '0;
      last_e = 1'b0;
    end else if (frame_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got digits %h err %0b, expected no frame at %0t",
                 digits_out, frame_err, $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_digits", 32'(digits_out), 32'(e[15:0]));
        check("frame_err", 32'(frame_err), 32'(e[16]));
      end
      last_d = digits_out;
      last_e = frame_err;
    end else begin
      check("hold_digits", 32'(digits_out), 32'(last_d));
      check("hold_err", 32'(frame_err), 32'(last_e));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst_n   = 1'b0;
    seg_in  = '0;
    dig_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("por_digits", 32'(digits_out), 32'h0);
    check("por_valid", 32'(frame_valid), 32'h0);
    check("por_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan 1,2,3,4 on digits 3..0.
    p0 = pulses;
    show(3, 1, 10); show(2, 2, 10); show(1, 3, 10); show(0, 4, 10);
    drive(7'h0, 4'h0, 10);
    check("basic_digits", 32'(digits_out), 32'h1234);
    check("basic_err", 32'(frame_err), 32'h0);
    check("basic_pulses", 32'(pulses - p0), 32'd1);

    // Latency: final pair first sampled at edge 1, frame_valid at edge STABLE+3.
    show(3, 8, 10); show(2, 7, 10); show(1, 6, 10);
    for (int e = 1; e <= 10; e++) begin
      seg_in  = ref_pat[5];
      dig_sel = 4'b0001;
      model_step(ref_pat[5], 4'b0001);
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", e), 32'(frame_valid), 32'(e == STABLE + 3));
      @(negedge clk);
    end
    drive(7'h0, 4'h0, 6);
    check("latency_digits", 32'(digits_out), 32'h8765);

    // Undecodable pattern on digit 2.
    show(3, 5, 10); drive(7'b1010101, 4'b0100, 10); show(1, 7, 10); show(0, 8, 10);
    drive(7'h0, 4'h0, 10);
    check("bad_digits", 32'(digits_out), 32'h5F78);
    check("bad_err", 32'(frame_err), 32'h1);

    // Short hold and non-one-hot select produce no capture.
    p0 = pulses;
    show(3, 1, 10); show(2, 2, 10); show(1, 3, 3);
    drive(ref_pat[3], 4'b0011, 20);
    show(0, 4, 10);
    drive(7'h0, 4'h0, 10);
    check("short_no_frame", 32'(pulses - p0), 32'd0);
    show(1, 3, 4);
    drive(7'h0, 4'h0, 10);
    check("short_frame", 32'(pulses - p0), 32'd1);
    check("short_digits", 32'(digits_out), 32'h1234);
    check("short_err", 32'(frame_err), 32'h0);

    // Recapture: latest value for digit 0 wins.
    p0 = pulses;
    show(0, 7, 10); show(1, 2, 10); show(2, 5, 10); show(0, 9, 10); show(3, 6, 10);
    drive(7'h0, 4'h0, 10);
    check("recap_pulses", 32'(pulses - p0), 32'd1);
    check("recap_digits", 32'(digits_out), 32'h6529);

    // Reset mid-frame discards partial capture.
    show(3, 1, 10); show(2, 2, 10); show(1, 3, 10);
    reset_pulse();
    p0 = pulses;
    show(0, 9, 10);
    drive(7'h0, 4'h0, 10);
    check("rst_partial_no_frame", 32'(pulses - p0), 32'd0);
    show(3, 9, 10); show(2, 9, 10); show(1, 9, 10); show(0, 9, 10);
    drive(7'h0, 4'h0, 10);
    check("rst_new_frame", 32'(pulses - p0), 32'd1);
    check("rst_digits", 32'(digits_out), 32'h9999);

    // Randomized scanning with glitches, bad patterns and bad selects.
    for (int h = 0; h < 300; h++) begin
      int         pv, ps, pn;
      logic [6:0] s;
      logic [3:0] d;
      pv = $urandom_range(0, 9);
      s  = ($urandom_range(0, 99) < 85) ? ref_pat[pv] : 7'($urandom_range(0, 127));
      ps = $urandom_range(0, 3);
      d  = ($urandom_range(0, 99) < 85) ? 4'(1 << ps) : 4'($urandom_range(0, 15));
      pn = $urandom_range(1, 8);
      drive(s, d, pn);
    end
    drive(7'h0, 4'h0, 12);

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
